// File: rtl/obuf_share_pkg.sv
// -----------------------------------------------------------------------------
// obuf_share_pkg
// Shared types and helpers for the output-pin sharing arbiter.
//   arb_state_e : arbiter FSM states (IDLE / OWN / GAP)
//   rr_pick_t   : result of a round-robin pick (index + one-hot vector)
//   rr_pick()   : first requester at or after a pointer, wrapping at num_req
// Vectors are sized for the largest supported requester count (8); callers
// zero-extend narrower request vectors.
// -----------------------------------------------------------------------------
package obuf_share_pkg;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned CNT_W   = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [IDX_W-1:0]   idx;
    logic [MAX_REQ-1:0] onehot;
  } rr_pick_t;

  // Cyclic priority search starting at ptr. An all-zero onehot means no
  // requester is active. ptr must be below num_req, so ptr+i stays below
  // 2*num_req and a single conditional subtract performs the wrap.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input logic [IDX_W-1:0]   ptr,
                                       input logic [CNT_W-1:0]   num_req);
    rr_pick_t         res;
    logic [CNT_W-1:0] cand;
    res = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      cand = {1'b0, ptr} + CNT_W'(i);
      if (cand >= num_req) begin
        cand = cand - num_req;
      end else begin
        cand = cand;
      end
      if ((res.onehot == '0) && (CNT_W'(i) < num_req) && req[cand[IDX_W-1:0]]) begin
        res.idx                      = cand[IDX_W-1:0];
        res.onehot[cand[IDX_W-1:0]] = 1'b1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/obuf_pwm_gate.sv
// -----------------------------------------------------------------------------
// obuf_pwm_gate
// Free-running PWM counter plus brightness compare, reusable by any pin bank.
//   clk_i    : system clock
//   rst_i    : synchronous active-high reset (counter to 0)
//   duty_i   : brightness, 0 = always off, all-ones = always on
//   pwm_on_o : high while the current PWM slot is "on"
// -----------------------------------------------------------------------------
module obuf_pwm_gate #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [PWM_BITS-1:0] duty_i,
  output logic                pwm_on_o
);

  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PWM_BITS-1:0] pwm_cnt_d;

  // Counter wraps naturally from all-ones to zero.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  // All-ones duty must be fully on; the plain compare alone would leave one
  // dark slot per period when the counter equals all-ones.
  assign pwm_on_o = (&duty_i) | (pwm_cnt_q < duty_i);

endmodule

// File: rtl/obuf_share_arbiter.sv
// -----------------------------------------------------------------------------
// obuf_share_arbiter
// Shares one bank of board output pins between NUM_REQ requesters with
// round-robin ownership, a minimum-tenure preemption timer, an all-low guard
// gap between owners, and a global PWM brightness gate.
//   clk_i  : system clock
//   rst_i  : synchronous active-high reset
//   req_i  : level request per requester
//   data_i : pin values, requester k at [k*PIN_W +: PIN_W]
//   duty_i : PWM brightness
//   gnt_o  : registered one-hot grant
//   pin_o  : registered pin values to the OBUF inputs
//   busy_o : registered, high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module obuf_share_arbiter
  import obuf_share_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned PIN_W       = 4,
  parameter int unsigned HOLD_CYCLES = 1024,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned PWM_BITS    = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*PIN_W-1:0] data_i,
  input  logic [PWM_BITS-1:0]      duty_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [PIN_W-1:0]         pin_o,
  output logic                     busy_o
);

  localparam int unsigned       HOLD_W   = $clog2(HOLD_CYCLES);
  localparam int unsigned       GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [PIN_W-1:0]    pin_q, pin_d;
  logic                busy_q, busy_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;

  logic                pwm_on_s;
  logic [MAX_REQ-1:0]  req_pad_s;
  rr_pick_t            pick_s;
  logic                pick_any_s;
  logic [PIN_W-1:0]    owner_data_s;
  logic                owner_req_s;
  logic                others_req_s;

  obuf_pwm_gate #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm_gate (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .duty_i   (duty_i),
    .pwm_on_o (pwm_on_s)
  );

  // Request decode: padded vector, round-robin candidate, owner data/req.
  always_comb begin
    req_pad_s                 = '0;
    req_pad_s[NUM_REQ-1:0]    = req_i;
    pick_s                    = rr_pick(req_pad_s, rr_ptr_q, CNT_W'(NUM_REQ));
    pick_any_s                = |pick_s.onehot;
    owner_req_s               = req_pad_s[owner_q];
    // gnt_q is the owner's one-hot while in OWN, so this masks out the owner.
    others_req_s              = |(req_i & ~gnt_q);
    owner_data_s              = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      owner_data_s = (owner_q == IDX_W'(k)) ? data_i[k*PIN_W +: PIN_W] : owner_data_s;
    end
  end

  // Arbiter next-state and output logic.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    pin_d      = '0;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any_s) begin
          state_d    = ST_OWN;
          gnt_d      = pick_s.onehot[NUM_REQ-1:0];
          owner_d    = pick_s.idx;
          hold_cnt_d = '0;
        end else begin
          gnt_d = '0;
        end
      end
      ST_OWN: begin
        // Release and preempt collapse into one exit path.
        if (!owner_req_s || ((hold_cnt_q == HOLD_MAX) && others_req_s)) begin
          state_d    = ST_GAP;
          gnt_d      = '0;
          rr_ptr_d   = (owner_q == LAST_IDX) ? IDX_W'(0) : (owner_q + IDX_W'(1));
          hold_cnt_d = '0;
          gap_cnt_d  = '0;
        end else begin
          pin_d      = owner_data_s & {PIN_W{pwm_on_s}};
          hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : (hold_cnt_q + HOLD_W'(1));
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          if (pick_any_s) begin
            state_d    = ST_OWN;
            gnt_d      = pick_s.onehot[NUM_REQ-1:0];
            owner_d    = pick_s.idx;
            hold_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      pin_q      <= '0;
      busy_q     <= 1'b0;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      pin_q      <= pin_d;
      busy_q     <= busy_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign gnt_o  = gnt_q;
  assign pin_o  = pin_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_obuf_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_obuf_share_arbiter
// Directed self-checking bench for obuf_share_arbiter (HOLD_CYCLES=16,
// GAP_CYCLES=2, 4 requesters x 4 pins, 8-bit PWM). Inputs change and outputs
// are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_obuf_share_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  req_i;
  logic [15:0] data_i;
  logic [7:0]  duty_i;
  logic [3:0]  gnt_o;
  logic [3:0]  pin_o;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;

  obuf_share_arbiter #(
    .NUM_REQ     (4),
    .PIN_W       (4),
    .HOLD_CYCLES (16),
    .GAP_CYCLES  (2),
    .PWM_BITS    (8)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .req_i  (req_i),
    .data_i (data_i),
    .duty_i (duty_i),
    .gnt_o  (gnt_o),
    .pin_o  (pin_o),
    .busy_o (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_i = 4'b0000;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i  = 1'b1;
    req_i  = 4'b0000;
    data_i = 16'hFFFF;
    duty_i = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({gnt_o, pin_o, busy_o} !== 9'b0) begin
        failures++;
        $display("FAIL reset_hold: gnt=%b pin=%h busy=%b, expected all zero", gnt_o, pin_o, busy_o);
      end
    end
    rst_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if ({gnt_o, pin_o, busy_o} !== 9'b0) begin
        failures++;
        $display("FAIL idle_quiet: cycle %0d gnt=%b pin=%h busy=%b, expected all zero", c, gnt_o, pin_o, busy_o);
      end
    end
  endtask

  task automatic test_single_owner();
    do_reset();
    data_i = 16'h5A37;
    duty_i = 8'hFF;
    req_i  = 4'b0100;
    tick();
    checks++;
    if (gnt_o !== 4'b0100 || pin_o !== 4'h0 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL single_grant: gnt=%b pin=%h busy=%b, expected 0100/0/1", gnt_o, pin_o, busy_o);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (gnt_o !== 4'b0100 || pin_o !== 4'hA) begin
        failures++;
        $display("FAIL single_pins: gnt=%b pin=%h, expected 0100/a", gnt_o, pin_o);
      end
    end
    req_i = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (gnt_o !== 4'b0000 || pin_o !== 4'h0 || busy_o !== 1'b1) begin
        failures++;
        $display("FAIL single_gap: gap cycle %0d gnt=%b pin=%h busy=%b, expected 0000/0/1", c, gnt_o, pin_o, busy_o);
      end
    end
    tick();
    checks++;
    if (gnt_o !== 4'b0000 || pin_o !== 4'h0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL single_idle: gnt=%b pin=%h busy=%b, expected 0000/0/0", gnt_o, pin_o, busy_o);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic [3:0] exp_p;
    do_reset();
    data_i = 16'h4321;
    duty_i = 8'hFF;
    req_i  = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'b0001 << (i % 4);
      exp_p = 4'((i % 4) + 1);
      for (int j = 0; j < 5; j++) begin
        checks++;
        if (gnt_o !== exp_g) begin
          failures++;
          $display("FAIL rr_grant: turn %0d cycle %0d gnt=%b, expected %b", i, j, gnt_o, exp_g);
        end
        if (j == 2) begin
          checks++;
          if (pin_o !== exp_p) begin
            failures++;
            $display("FAIL rr_pins: turn %0d pin=%h, expected %h", i, pin_o, exp_p);
          end
        end
        if (j < 4) tick();
      end
      req_i = 4'b1111 & ~exp_g;
      tick();
      req_i = 4'b1111;
      checks++;
      if (gnt_o !== 4'b0000 || pin_o !== 4'h0 || busy_o !== 1'b1) begin
        failures++;
        $display("FAIL rr_gap1: turn %0d gnt=%b pin=%h busy=%b, expected 0000/0/1", i, gnt_o, pin_o, busy_o);
      end
      tick();
      checks++;
      if (gnt_o !== 4'b0000 || pin_o !== 4'h0) begin
        failures++;
        $display("FAIL rr_gap2: turn %0d gnt=%b pin=%h, expected 0000/0", i, gnt_o, pin_o);
      end
      tick();
    end
  endtask

  task automatic test_preempt();
    int n;
    do_reset();
    data_i = 16'hFFFF;
    duty_i = 8'hFF;
    req_i  = 4'b0001;
    tick();
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (gnt_o !== 4'b0001) break;
      n++;
      if (n == 3) req_i = 4'b0101;
      tick();
    end
    checks++;
    if (n !== 16) begin
      failures++;
      $display("FAIL preempt_tenure: owner 0 held %0d cycles, expected 16", n);
    end
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (gnt_o !== 4'b0000 || busy_o !== 1'b1) begin
        failures++;
        $display("FAIL preempt_gap: gap cycle %0d gnt=%b busy=%b, expected 0000/1", c, gnt_o, busy_o);
      end
      tick();
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (gnt_o !== 4'b0100) begin
        failures++;
        $display("FAIL preempt_new_owner: cycle %0d gnt=%b, expected 0100", c, gnt_o);
      end
      if (c < 4) tick();
    end
    req_i = 4'b0001;
    tick();
    tick();
    checks++;
    if (gnt_o !== 4'b0000) begin
      failures++;
      $display("FAIL preempt_release_gap: gnt=%b, expected 0000", gnt_o);
    end
    tick();
    checks++;
    if (gnt_o !== 4'b0001) begin
      failures++;
      $display("FAIL preempt_regrant: gnt=%b, expected 0001", gnt_o);
    end
  endtask

  task automatic test_pwm();
    int on_cnt [4];
    int bad;
    do_reset();
    data_i = 16'h000F;
    duty_i = 8'h40;
    req_i  = 4'b0001;
    tick();
    tick();
    for (int p = 0; p < 4; p++) on_cnt[p] = 0;
    bad = 0;
    for (int c = 0; c < 512; c++) begin
      for (int p = 0; p < 4; p++) on_cnt[p] += int'(pin_o[p]);
      if (gnt_o !== 4'b0001) bad++;
      tick();
    end
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (on_cnt[p] !== 128) begin
        failures++;
        $display("FAIL pwm_duty40: pin %0d high %0d of 512 cycles, expected 128", p, on_cnt[p]);
      end
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL pwm_owner_kept: %0d cycles without grant 0001, expected 0", bad);
    end
    duty_i = 8'h00;
    tick();
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      if (pin_o !== 4'h0) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL pwm_duty0: %0d cycles with pins lit, expected 0", bad);
    end
    duty_i = 8'hFF;
    tick();
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      if (pin_o !== 4'hF) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL pwm_duty_full: %0d cycles with pins not f, expected 0", bad);
    end
  endtask

  task automatic test_midop_reset();
    do_reset();
    data_i = 16'hFFFF;
    duty_i = 8'hFF;
    req_i  = 4'b0010;
    tick();
    tick();
    tick();
    checks++;
    if (gnt_o !== 4'b0010 || pin_o !== 4'hF) begin
      failures++;
      $display("FAIL midop_setup: gnt=%b pin=%h, expected 0010/f", gnt_o, pin_o);
    end
    req_i = 4'b0000;
    tick();
    checks++;
    if (busy_o !== 1'b1 || gnt_o !== 4'b0000) begin
      failures++;
      $display("FAIL midop_in_gap: busy=%b gnt=%b, expected 1/0000", busy_o, gnt_o);
    end
    rst_i = 1'b1;
    tick();
    checks++;
    if ({gnt_o, pin_o, busy_o} !== 9'b0) begin
      failures++;
      $display("FAIL midop_reset_gap: gnt=%b pin=%h busy=%b, expected all zero", gnt_o, pin_o, busy_o);
    end
    rst_i = 1'b0;
    req_i = 4'b1111;
    tick();
    checks++;
    if (gnt_o !== 4'b0001) begin
      failures++;
      $display("FAIL midop_restart_ptr: gnt=%b, expected 0001", gnt_o);
    end
    tick();
    checks++;
    if (pin_o !== 4'hF || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL midop_own_pins: pin=%h busy=%b, expected f/1", pin_o, busy_o);
    end
    rst_i = 1'b1;
    tick();
    checks++;
    if ({gnt_o, pin_o, busy_o} !== 9'b0) begin
      failures++;
      $display("FAIL midop_reset_own: gnt=%b pin=%h busy=%b, expected all zero", gnt_o, pin_o, busy_o);
    end
    rst_i = 1'b0;
    req_i = 4'b0000;
    tick();
    checks++;
    if ({gnt_o, pin_o, busy_o} !== 9'b0) begin
      failures++;
      $display("FAIL midop_after_release: gnt=%b pin=%h busy=%b, expected all zero", gnt_o, pin_o, busy_o);
    end
  endtask

  initial begin
    rst_i  = 1'b1;
    req_i  = 4'b0000;
    data_i = 16'h0000;
    duty_i = 8'h00;
    test_reset();
    test_single_owner();
    test_round_robin();
    test_preempt();
    test_pwm();
    test_midop_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
